// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Two-read / one-write register file for the 5-stage MIPS pipe with a
// built-in write scoreboard. Decode registers a destination at issue and
// writeback retires it. A per-register counter tracks the in-flight writes.
// Decode is stalled while one of its sources still waits on a write, or while
// its destination counter has no room for another in-flight write.
// Register 0 reads as zero. Writes to register 0 are discarded, and
// register 0 is never tracked.
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int PEND_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_en1,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  output logic [DATA_W-1:0] o_rd_data1,
  input  logic              i_rd_en2,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic [DATA_W-1:0] o_rd_data2,
  input  logic              i_issue_en,
  input  logic [ADDR_W-1:0] i_issue_addr,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_stall,
  output logic              o_err_underflow
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Architectural state
  logic [DATA_W-1:0] r_regs [NREG];
  logic [PEND_W-1:0] r_pend [NREG];
  logic              r_err_underflow;

  // Combinational views of the state at the addressed registers
  logic [DATA_W-1:0] w_reg_rd1;
  logic [DATA_W-1:0] w_reg_rd2;
  logic [PEND_W-1:0] w_pend_rd1;
  logic [PEND_W-1:0] w_pend_rd2;
  logic [PEND_W-1:0] w_pend_iss;
  logic [PEND_W-1:0] w_pend_wb;

  // Hazards and scoreboard update controls
  logic              w_h1;
  logic              w_h2;
  logic              w_hf;
  logic              w_stall;
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;
  logic              w_wb_live;
  logic              w_underflow;

  // Read-port value: a disabled port or register 0 returns zero.
  // A same-cycle writeback is forwarded ahead of the stored value.
  function automatic logic [DATA_W-1:0] f_read(
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic              wb_en,
    input logic [ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_data,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (!en) begin
      val = DATA_ZERO;
    end else if (addr == ADDR_ZERO) begin
      val = DATA_ZERO;
    end else if (wb_en && (wb_addr == addr)) begin
      val = wb_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Source hazard: the source still has a pending write. A writeback in the
  // same cycle clears the hazard only when it retires the last pending write.
  function automatic logic f_src_hazard(
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic [PEND_W-1:0] pend,
    input logic              wb_en,
    input logic [ADDR_W-1:0] wb_addr
  );
    logic last_retire;
    last_retire = wb_en && (wb_addr == addr) && (pend == PEND_ONE);
    return en && (addr != ADDR_ZERO) && (pend != PEND_ZERO) && !last_retire;
  endfunction

  // Full hazard: the destination counter is saturated. The hazard is lifted
  // when a retire to the same register frees a slot in the same cycle.
  function automatic logic f_full_hazard(
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic [PEND_W-1:0] pend,
    input logic              wb_en,
    input logic [ADDR_W-1:0] wb_addr
  );
    return en && (addr != ADDR_ZERO) && (pend == PEND_MAX) &&
           !(wb_en && (wb_addr == addr));
  endfunction

  assign w_reg_rd1  = r_regs[i_rd_addr1];
  assign w_reg_rd2  = r_regs[i_rd_addr2];
  assign w_pend_rd1 = r_pend[i_rd_addr1];
  assign w_pend_rd2 = r_pend[i_rd_addr2];
  assign w_pend_iss = r_pend[i_issue_addr];
  assign w_pend_wb  = r_pend[i_wb_addr];
  assign w_wb_live  = i_wb_en && (i_wb_addr != ADDR_ZERO);

  // Hazard detection for both sources and for the issuing destination
  always_comb begin
    w_h1    = f_src_hazard(i_rd_en1, i_rd_addr1, w_pend_rd1, i_wb_en, i_wb_addr);
    w_h2    = f_src_hazard(i_rd_en2, i_rd_addr2, w_pend_rd2, i_wb_en, i_wb_addr);
    w_hf    = f_full_hazard(i_issue_en, i_issue_addr, w_pend_iss, i_wb_en, i_wb_addr);
    w_stall = w_h1 | w_h2 | w_hf;
  end

  // Per-register increment/decrement requests. Register 0 is never tracked.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int a = 1; a < NREG; a++) begin
      w_inc[a] = i_issue_en && !w_stall && (i_issue_addr == ADDR_W'(a));
      w_dec[a] = i_wb_en && (i_wb_addr == ADDR_W'(a)) && (r_pend[a] != PEND_ZERO);
    end
  end

  // Writeback with nothing outstanding, unless an issue to the same
  // register is accepted in the same cycle.
  always_comb begin
    if (w_wb_live && (w_pend_wb == PEND_ZERO) && !w_inc[i_wb_addr]) begin
      w_underflow = 1'b1;
    end else begin
      w_underflow = 1'b0;
    end
  end

  // Drive the outputs. Reads and stall are forced low while reset is held.
  always_comb begin
    o_rd_data1 = DATA_ZERO;
    o_rd_data2 = DATA_ZERO;
    o_stall    = 1'b0;
    if (i_rst) begin
      o_rd_data1 = DATA_ZERO;
      o_rd_data2 = DATA_ZERO;
      o_stall    = 1'b0;
    end else begin
      o_rd_data1 = f_read(i_rd_en1, i_rd_addr1, i_wb_en, i_wb_addr, i_wb_data, w_reg_rd1);
      o_rd_data2 = f_read(i_rd_en2, i_rd_addr2, i_wb_en, i_wb_addr, i_wb_data, w_reg_rd2);
      o_stall    = w_stall;
    end
  end

  assign o_err_underflow = r_err_underflow;

  // Register storage: the writeback port updates any register except r0
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int a = 0; a < NREG; a++) begin
        r_regs[a] <= DATA_ZERO;
      end
    end else if (w_wb_live) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Pending-write counters. An increment and a decrement in the same cycle
  // cancel. Requests are gated so that a counter never wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int a = 0; a < NREG; a++) begin
        r_pend[a] <= PEND_ZERO;
      end
    end else begin
      r_pend[0] <= PEND_ZERO;
      for (int a = 1; a < NREG; a++) begin
        case ({w_inc[a], w_dec[a]})
          2'b10:   r_pend[a] <= r_pend[a] + PEND_ONE;
          2'b01:   r_pend[a] <= r_pend[a] - PEND_ONE;
          default: r_pend[a] <= r_pend[a];
        endcase
      end
    end
  end

  // Sticky underflow flag; only reset clears it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_underflow <= 1'b0;
    end else begin
      r_err_underflow <= r_err_underflow | w_underflow;
    end
  end

endmodule
